// File: rtl/swu_stream_arbiter.sv
// Round-robin merge of four sliding-window channels into one tagged stream; frame_done when all channels end.
// Latency: push at cycle N -> out_val at N+2 when the output register is free; 1 word/cycle sustained.
// Backpressure: out_* hold while out_val & !out_ready; full FIFOs drop pushes (sticky ovf). Option: SWU_ARB_STAT_EN adds drop_cnt.

module swu_arb_fifo #(
  parameter int W     = 9,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  // full/empty are start-of-cycle flags, so a push into a full FIFO drops even if a pop happens too
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (pop && !empty) rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

module swu_stream_arbiter #(
  parameter int DATA_W     = 7,
  parameter int FIFO_DEPTH = 4
`ifdef SWU_ARB_STAT_EN
  , parameter int CNT_W    = 16
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] slide_data_0,
  input  logic [DATA_W-1:0] slide_data_1,
  input  logic [DATA_W-1:0] slide_data_2,
  input  logic [DATA_W-1:0] slide_data_3,
  input  logic              data_val_0,
  input  logic              data_val_1,
  input  logic              data_val_2,
  input  logic              data_val_3,
  input  logic              trans_done_0,
  input  logic              trans_done_1,
  input  logic              trans_done_2,
  input  logic              trans_done_3,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_ch,
  output logic              out_last,
  output logic              out_mark,
  output logic              out_val,
  input  logic              out_ready,
  output logic              frame_done,
  output logic [3:0]        ovf
`ifdef SWU_ARB_STAT_EN
  , output logic [CNT_W-1:0] drop_cnt
`endif
);
  localparam int EW = DATA_W + 2;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FEND} state_t;

  state_t            state, state_n;
  logic [DATA_W-1:0] sd [4];
  logic [EW-1:0]     din [4];
  logic [EW-1:0]     dout [4];
  logic [3:0]        dv, td, td_q, rise, push, drop, empty, full, pop, done_seen;
  logic [1:0]        rr_ptr, gnt, idx;
  logic              gnt_vld, load;

  assign sd[0] = slide_data_0;
  assign sd[1] = slide_data_1;
  assign sd[2] = slide_data_2;
  assign sd[3] = slide_data_3;
  assign dv    = {data_val_3, data_val_2, data_val_1, data_val_0};
  assign td    = {trans_done_3, trans_done_2, trans_done_1, trans_done_0};
  assign rise  = td & ~td_q;
  assign push  = dv | rise;
  assign drop  = push & full;

  for (genvar c = 0; c < 4; c++) begin : g_ch
    // entry = {mark, last, data}; a bare done edge becomes a data-less marker
    assign din[c] = {rise[c] & ~dv[c], rise[c], dv[c] ? sd[c] : {DATA_W{1'b0}}};

    swu_arb_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push[c]),
      .din   (din[c]),
      .pop   (pop[c]),
      .dout  (dout[c]),
      .empty (empty[c]),
      .full  (full[c])
    );
  end

  // descending scan so the lowest offset from rr_ptr wins
  always_comb begin
    gnt     = rr_ptr;
    gnt_vld = 1'b0;
    idx     = '0;
    for (int i = 3; i >= 0; i--) begin
      idx = rr_ptr + 2'(i);
      if (!empty[idx]) begin
        gnt     = idx;
        gnt_vld = 1'b1;
      end
    end
  end

  assign load = gnt_vld && (!out_val || out_ready);
  assign pop  = load ? (4'b0001 << gnt) : 4'b0000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_val  <= 1'b0;
      out_data <= '0;
      out_ch   <= '0;
      out_last <= 1'b0;
      out_mark <= 1'b0;
      rr_ptr   <= '0;
    end else if (load) begin
      out_val                        <= 1'b1;
      {out_mark, out_last, out_data} <= dout[gnt];
      out_ch                         <= gnt;
      rr_ptr                         <= gnt + 2'd1;
    end else if (out_ready) begin
      out_val <= 1'b0;
    end
  end

  // a done edge seen during FEND belongs to the next frame, so set wins over clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      td_q      <= '0;
      ovf       <= '0;
      done_seen <= '0;
      state     <= IDLE;
    end else begin
      td_q      <= td;
      ovf       <= ovf | drop;
      done_seen <= ((state == FEND) ? 4'b0000 : done_seen) | rise;
      state     <= state_n;
    end
  end

  always_comb begin
    state_n    = state;
    frame_done = 1'b0;
    case (state)
      IDLE:  if (|push || |done_seen) state_n = RUN;
      RUN:   if (&done_seen) state_n = DRAIN;
      DRAIN: if (&empty && (!out_val || out_ready)) state_n = FEND;
      FEND: begin
        frame_done = 1'b1;
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef SWU_ARB_STAT_EN
  logic [2:0]     drop_num;
  logic [CNT_W:0] cnt_sum;

  assign drop_num = 3'(drop[0]) + 3'(drop[1]) + 3'(drop[2]) + 3'(drop[3]);
  assign cnt_sum  = {1'b0, drop_cnt} + (CNT_W+1)'(drop_num);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt <= '0;
    else        drop_cnt <= cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
  end
`endif
endmodule

// File: tb/tb_swu_stream_arbiter.sv
// Bench for swu_stream_arbiter: vector table, directed frame/backpressure sequences, random vs queue model.
module tb_swu_stream_arbiter;
  localparam int DW    = 7;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic          mark;
    logic          last;
    logic [DW-1:0] data;
  } ent_t;

  typedef struct {
    logic [3:0]    dv;
    logic [DW-1:0] base;
    logic          exp_val;
    logic [1:0]    exp_ch;
    logic [DW-1:0] exp_data;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] sd [4];
  logic [3:0]    dv, td;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    out_ch;
  logic          out_last, out_mark, out_val, frame_done;
  logic [3:0]    ovf;
`ifdef SWU_ARB_STAT_EN
  logic [15:0]   drop_cnt;
`endif

  int checks = 0;
  int errors = 0;

  swu_stream_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .slide_data_0 (sd[0]),
    .slide_data_1 (sd[1]),
    .slide_data_2 (sd[2]),
    .slide_data_3 (sd[3]),
    .data_val_0   (dv[0]),
    .data_val_1   (dv[1]),
    .data_val_2   (dv[2]),
    .data_val_3   (dv[3]),
    .trans_done_0 (td[0]),
    .trans_done_1 (td[1]),
    .trans_done_2 (td[2]),
    .trans_done_3 (td[3]),
    .out_data     (out_data),
    .out_ch       (out_ch),
    .out_last     (out_last),
    .out_mark     (out_mark),
    .out_val      (out_val),
    .out_ready    (out_ready),
    .frame_done   (frame_done),
`ifdef SWU_ARB_STAT_EN
    .drop_cnt     (drop_cnt),
`endif
    .ovf          (ovf)
  );

  always #5 clk = ~clk;

  // reference model state
  ent_t       mq [4][$];
  logic       m_val;
  ent_t       m_ent;
  logic [1:0] m_ch;
  int         m_rr;
  logic [3:0] m_ovf, m_prev_td;
  int         m_drops;

  vec_t        tbl [14];
  logic [10:0] got [$];
  int          got_t [$];
  int          fd_t [$];
  logic [10:0] exp_w [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    dv = '0;
    td = '0;
    for (int c = 0; c < 4; c++) sd[c] = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic model_reset();
    for (int c = 0; c < 4; c++) mq[c].delete();
    m_val = 1'b0; m_ent = '0; m_ch = '0; m_rr = 0;
    m_ovf = '0; m_prev_td = '0; m_drops = 0;
  endtask

  // advances the model across one clock edge using the inputs currently applied
  task automatic model_step();
    bit   full0 [4];
    bit   found, rise;
    int   g;
    ent_t e;
    for (int c = 0; c < 4; c++) full0[c] = (mq[c].size() == DEPTH);
    if (!m_val || out_ready) begin
      found = 0;
      for (int k = 0; k < 4; k++) begin
        g = (m_rr + k) % 4;
        if (!found && mq[g].size() > 0) begin
          found = 1;
          m_ent = mq[g].pop_front();
          m_ch  = 2'(g);
          m_rr  = (g + 1) % 4;
        end
      end
      m_val = found;
    end
    for (int c = 0; c < 4; c++) begin
      rise = td[c] && !m_prev_td[c];
      if (dv[c] || rise) begin
        if (full0[c]) begin
          m_ovf[c] = 1'b1;
          if (m_drops < 65535) m_drops++;
        end else begin
          e.mark = rise && !dv[c];
          e.last = rise;
          e.data = dv[c] ? sd[c] : '0;
          mq[c].push_back(e);
        end
      end
    end
    m_prev_td = td;
  endtask

  initial begin
    // T1: reset values, then asynchronous reset mid-stream
    idle_inputs();
    out_ready = 1'b0;
    #1;
    chk("t1_reset_init", {out_val, out_data, out_ch, out_last, out_mark, frame_done, ovf}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    dv = 4'hF;
    for (int c = 0; c < 4; c++) sd[c] = 7'(c + 1);
    step();
    idle_inputs();
    step();
    chk("t1_pre_val", out_val, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_async", {out_val, out_data, out_ch, out_last, out_mark, frame_done, ovf}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t1_post_idle", out_val, 0);
    end

    // T2: round-robin table, 3 words per channel pushed together
    for (int i = 0; i < 14; i++) begin
      tbl[i].dv      = (i < 3) ? 4'hF : 4'h0;
      tbl[i].base    = 7'(i);
      tbl[i].exp_val = (i >= 1 && i <= 12);
      tbl[i].exp_ch  = (i >= 1) ? 2'((i - 1) % 4) : 2'd0;
      tbl[i].exp_data = (i >= 1) ? 7'(((i - 1) % 4) * 16 + (i - 1) / 4) : 7'd0;
    end
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      dv = tbl[i].dv;
      for (int c = 0; c < 4; c++) sd[c] = 7'(c * 16) + tbl[i].base;
      step();
      chk("t2_val", out_val, tbl[i].exp_val);
      if (tbl[i].exp_val) chk("t2_word", {out_ch, out_data}, {tbl[i].exp_ch, tbl[i].exp_data});
    end

    // T3: output held stable under backpressure
    do_reset();
    dv = 4'b0100;
    sd[2] = 7'h15;
    step();
    idle_inputs();
    chk("t3_lat1", out_val, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3_hold", {out_val, out_ch, out_data}, {1'b1, 2'd2, 7'h15});
    end
    out_ready = 1'b1;
    step();
    chk("t3_xfer", out_val, 0);

    // T4: overflow on ch1 behind an occupied output register
    do_reset();
    dv = 4'b0001;
    sd[0] = 7'h7F;
    step();
    for (int k = 1; k <= 6; k++) begin
      idle_inputs();
      dv = 4'b0010;
      sd[1] = 7'(k);
      step();
    end
    idle_inputs();
    step();
    chk("t4_ovf", ovf, 4'b0010);
`ifdef SWU_ARB_STAT_EN
    chk("t4_drop_cnt", drop_cnt, 2);
`endif
    chk("t4_head", {out_val, out_ch, out_data}, {1'b1, 2'd0, 7'h7F});
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("t4_order", {out_val, out_ch, out_data}, {1'b1, 2'd1, 7'(k)});
    end
    step();
    chk("t4_empty", out_val, 0);

    // T5/T6: frame end with last/marker words, then a second frame pushed during FEND
    for (int c = 0; c < 4; c++) begin
      exp_w[c]      = {2'(c), 1'b0, 1'b0, 7'(8'h10 + c)};
      exp_w[8 + c]  = {2'(c), 1'b0, 1'b0, 7'(8'h40 + c)};
      exp_w[12 + c] = {2'(c), 1'b1, 1'b1, 7'h00};
    end
    exp_w[4] = {2'd0, 1'b0, 1'b1, 7'h20};
    exp_w[5] = {2'd1, 1'b0, 1'b1, 7'h21};
    exp_w[6] = {2'd2, 1'b1, 1'b1, 7'h00};
    exp_w[7] = {2'd3, 1'b1, 1'b1, 7'h00};
    do_reset();
    out_ready = 1'b1;
    begin
      int inj = 0;
      for (int t = 0; t < 60; t++) begin
        idle_inputs();
        if (t == 0) begin
          dv = 4'hF;
          for (int c = 0; c < 4; c++) sd[c] = 7'(8'h10 + c);
        end else if (t == 1) begin
          dv = 4'b0011;
          td = 4'hF;
          for (int c = 0; c < 4; c++) sd[c] = 7'(8'h20 + c);
        end else if (inj == 1) begin
          dv = 4'hF;
          for (int c = 0; c < 4; c++) sd[c] = 7'(8'h40 + c);
          inj = 2;
        end else if (inj == 2) begin
          td = 4'hF;
          inj = 3;
        end
        step();
        if (out_val) begin
          got.push_back({out_ch, out_mark, out_last, out_data});
          got_t.push_back(t);
        end
        if (frame_done) begin
          fd_t.push_back(t);
          if (inj == 0) inj = 1;
        end
      end
    end
    chk("t5_nwords", got.size(), 16);
    for (int i = 0; i < 16 && i < got.size(); i++) chk("t5_word", got[i], exp_w[i]);
    chk("t5_nframe_done", fd_t.size(), 2);
    if (fd_t.size() >= 2 && got_t.size() >= 16) begin
      chk("t5_fd_timing", fd_t[0], got_t[7] + 1);
      chk("t6_fd_timing", fd_t[1], got_t[15] + 1);
    end

    // random stimulus against the queue model
    do_reset();
    model_reset();
    for (int n = 0; n < 600; n++) begin
      for (int c = 0; c < 4; c++) begin
        dv[c] = ($urandom_range(0, 99) < 35);
        sd[c] = 7'($urandom);
        if ($urandom_range(0, 7) == 0) td[c] = ~td[c];
      end
      out_ready = ($urandom_range(0, 99) < 65);
      model_step();
      step();
      chk("rnd_val", out_val, m_val);
      if (m_val) chk("rnd_word", {out_ch, out_mark, out_last, out_data},
                     {m_ch, m_ent.mark, m_ent.last, m_ent.data});
      chk("rnd_ovf", ovf, m_ovf);
`ifdef SWU_ARB_STAT_EN
      chk("rnd_drop_cnt", drop_cnt, m_drops);
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
